// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// booth_pkg: radix-4 Booth code constants, encoder FSM state, negation helper
// Rev 1.0
// ============================================================================
package booth_pkg;

  // Widest operand neg_ext supports; callers keep WIDTH <= BOOTH_MAX_W-2.
  localparam int BOOTH_MAX_W = 64;

  localparam logic [2:0] BOOTH_ZERO_P = 3'b000;
  localparam logic [2:0] BOOTH_P1_A   = 3'b001;
  localparam logic [2:0] BOOTH_P1_B   = 3'b010;
  localparam logic [2:0] BOOTH_P2     = 3'b011;
  localparam logic [2:0] BOOTH_M2     = 3'b100;
  localparam logic [2:0] BOOTH_M1_A   = 3'b101;
  localparam logic [2:0] BOOTH_M1_B   = 3'b110;
  localparam logic [2:0] BOOTH_ZERO_N = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } booth_state_e;

  // Two's-complement negation of an already sign-extended operand; the caller
  // keeps the low WIDTH+1 bits, which is the result modulo 2^(WIDTH+1).
  function automatic logic [BOOTH_MAX_W:0] neg_ext(input logic [BOOTH_MAX_W:0] a_ext);
    return (~a_ext) + {{BOOTH_MAX_W{1'b0}}, 1'b1};
  endfunction

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth2_pp_encoder.sv
`default_nettype none
// ============================================================================
// booth2_pp_encoder: streams one {Booth code, A, -A} beat per partial product
// Rev 1.0
// ============================================================================
module booth2_pp_encoder
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               code,
  output logic [WIDTH-1:0]         A_out,
  output logic [WIDTH:0]           inversed_A,
  output logic [$clog2(WIDTH/2)-1:0] pp_idx,
  output logic                     pp_last
);

  localparam int NPP   = WIDTH / 2;
  localparam int IDX_W = $clog2(NPP);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPP - 1);

  booth_state_e          state_q, state_d;
  logic [WIDTH:0]        sr_q, sr_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH:0]        inv_q, inv_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  out_valid_q, out_valid_d;

  logic [BOOTH_MAX_W:0]            a_sext;
  logic [BOOTH_MAX_W:0]            neg_full;
  logic [BOOTH_MAX_W-WIDTH-1:0]    neg_unused;

  assign a_sext     = {{(BOOTH_MAX_W + 1 - WIDTH){A[WIDTH-1]}}, A};
  assign neg_full   = neg_ext(a_sext);
  assign neg_unused = neg_full[BOOTH_MAX_W:WIDTH+1];

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    a_d         = a_q;
    inv_d       = inv_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d         = A;
          inv_d       = neg_full[WIDTH:0];
          sr_d        = {B, 1'b0};
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            // Arithmetic shift keeps the multiplier sign feeding the top group.
            sr_d  = {{2{sr_q[WIDTH]}}, sr_q[WIDTH:2]};
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      a_q         <= '0;
      inv_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      a_q         <= a_d;
      inv_q       <= inv_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign code       = sr_q[2:0];
  assign A_out      = a_q;
  assign inversed_A = inv_q;
  assign pp_idx     = idx_q;
  assign pp_last    = out_valid_q && (idx_q == LAST_IDX);

endmodule : booth2_pp_encoder
`default_nettype wire

// File: tb/tb_booth2_pp_encoder.sv
`default_nettype none
// Directed-vector bench for booth2_pp_encoder (WIDTH=16, 8 beats per operation).
module tb_booth2_pp_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  code;
  logic [15:0] A_out;
  logic [16:0] inversed_A;
  logic [2:0]  pp_idx;
  logic        pp_last;

  int total = 0;
  int bad   = 0;

  booth2_pp_encoder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .code(code), .A_out(A_out), .inversed_A(inversed_A),
    .pp_idx(pp_idx), .pp_last(pp_last)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-written Booth digit value of a code, used only to rebuild a product.
  function automatic int booth_val(input logic [2:0] c);
    case (c)
      3'b001, 3'b010: return 1;
      3'b011:         return 2;
      3'b100:         return -2;
      3'b101, 3'b110: return -1;
      default:        return 0;
    endcase
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    A = a; B = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    step(); step();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || code !== 3'b000 || A_out !== 16'h0 ||
        inversed_A !== 17'h0 || pp_idx !== 3'd0 || pp_last !== 1'b0) begin
      bad++;
      $display("FAIL reset: rdy=%b vld=%b code=%b A=%h inv=%h idx=%0d last=%b, want 1 0 000 0000 00000 0 0",
               in_ready, out_valid, code, A_out, inversed_A, pp_idx, pp_last);
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp_code [8] = '{3'b110, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    out_ready = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_before: got %b want 1", in_ready); end
    start_op(16'h5C0B, 16'h0003);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || pp_idx !== 3'(i) || code !== exp_code[i] ||
          inversed_A !== 17'h1A3F5 || A_out !== 16'h5C0B || pp_last !== (i == 7)) begin
        bad++;
        $display("FAIL basic_beat%0d: vld=%b rdy=%b idx=%0d code=%b inv=%h A=%h last=%b, want 1 0 %0d %b 1a3f5 5c0b %b",
                 i, out_valid, in_ready, pp_idx, code, inversed_A, A_out, pp_last, i, exp_code[i], (i == 7));
      end
      step();
    end
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || pp_last !== 1'b0) begin
      bad++;
      $display("FAIL basic_end: vld=%b rdy=%b last=%b, want 0 1 0", out_valid, in_ready, pp_last);
    end
  endtask

  task automatic test_most_neg();
    out_ready = 1'b1;
    start_op(16'h8000, 16'hFFFF);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (code !== ((i == 0) ? 3'b110 : 3'b111) || inversed_A !== 17'h08000 || pp_idx !== 3'(i)) begin
        bad++;
        $display("FAIL most_neg_beat%0d: code=%b inv=%h idx=%0d, want %b 08000 %0d",
                 i, code, inversed_A, pp_idx, ((i == 0) ? 3'b110 : 3'b111), i);
      end
      step();
    end
  endtask

  task automatic test_neg_mult();
    longint sum = 0;
    out_ready = 1'b1;
    start_op(16'h0001, 16'h8000);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (code !== ((i == 7) ? 3'b100 : 3'b000)) begin
        bad++;
        $display("FAIL neg_mult_beat%0d: code=%b want %b", i, code, ((i == 7) ? 3'b100 : 3'b000));
      end
      sum += longint'(booth_val(code)) * longint'($signed(A_out)) * (longint'(1) << (2 * i));
      step();
    end
    total++;
    if (sum != -32768) begin bad++; $display("FAIL neg_mult_product: got %0d want -32768", sum); end
  endtask

  task automatic test_backpressure();
    logic [2:0] exp_code [8] = '{3'b000, 3'b010, 3'b110, 3'b001, 3'b100, 3'b001, 3'b010, 3'b000};
    int beat = 0, hs = 0, stalls = 0;
    out_ready = 1'b1;
    start_op(16'h0010, 16'h1234);
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid === 1'b1) begin
        total++;
        if (pp_idx !== 3'(beat) || code !== exp_code[beat] || inversed_A !== 17'h1FFF0) begin
          bad++;
          $display("FAIL bp_cyc%0d: idx=%0d code=%b inv=%h, want %0d %b 1fff0",
                   cyc, pp_idx, code, inversed_A, beat, exp_code[beat]);
        end
        if (beat == 2 && stalls < 3) begin
          out_ready = 1'b0;
          stalls++;
        end else begin
          out_ready = 1'b1;
          hs++;
          beat++;
        end
      end
      step();
    end
    out_ready = 1'b1;
    total++;
    if (hs != 8 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_total: handshakes=%0d vld=%b rdy=%b, want 8 0 1", hs, out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    start_op(16'h1234, 16'h5555);
    for (int i = 0; i < 4; i++) step();
    total++;
    if (pp_idx !== 3'd4 || out_valid !== 1'b1) begin
      bad++; $display("FAIL rmid_pre: idx=%0d vld=%b want 4 1", pp_idx, out_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || pp_last !== 1'b0) begin
      bad++; $display("FAIL rmid_abort: vld=%b rdy=%b last=%b want 0 1 0", out_valid, in_ready, pp_last);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_quiet: vld=%b want 0", out_valid); end
    start_op(16'h0000, 16'h0003);
    total++;
    if (out_valid !== 1'b1 || pp_idx !== 3'd0 || code !== 3'b110 || inversed_A !== 17'h0 || A_out !== 16'h0) begin
      bad++;
      $display("FAIL rmid_restart: vld=%b idx=%0d code=%b inv=%h A=%h want 1 0 110 00000 0000",
               out_valid, pp_idx, code, inversed_A, A_out);
    end
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_ignore_in_valid();
    logic [2:0] exp_code [8] = '{3'b110, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    out_ready = 1'b1;
    start_op(16'h5C0B, 16'h0003);
    A = 16'h0010; B = 16'h1234; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (in_ready !== 1'b0 || pp_idx !== 3'(i) || code !== exp_code[i] || A_out !== 16'h5C0B ||
          inversed_A !== 17'h1A3F5) begin
        bad++;
        $display("FAIL ign_beat%0d: rdy=%b idx=%0d code=%b A=%h inv=%h, want 0 %0d %b 5c0b 1a3f5",
                 i, in_ready, pp_idx, code, A_out, inversed_A, i, exp_code[i]);
      end
      step();
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL ign_gap: rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || pp_idx !== 3'd0 || code !== 3'b000 || A_out !== 16'h0010 || inversed_A !== 17'h1FFF0) begin
      bad++;
      $display("FAIL ign_accept: vld=%b idx=%0d code=%b A=%h inv=%h want 1 0 000 0010 1fff0",
               out_valid, pp_idx, code, A_out, inversed_A);
    end
    step();
    total++;
    if (pp_idx !== 3'd1 || code !== 3'b010) begin
      bad++; $display("FAIL ign_second: idx=%0d code=%b want 1 010", pp_idx, code);
    end
    for (int i = 0; i < 7; i++) step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL ign_single: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_most_neg();
    test_neg_mult();
    test_backpressure();
    test_reset_mid();
    test_ignore_in_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_booth2_pp_encoder
`default_nettype wire
